dsram_wr_sched: RTL and testbench

DSRAM_WR_SCHED -- requirements
Module: dsram_wr_sched

---
 rtl/dsram_wr_sched.sv | 201 ++++++++++++++++++++
 tb/tb_dsram_wr_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsram_wr_sched.sv
// dsram_wr_sched: data-array write scheduler. Stores are held in an in-order
// queue and arbitrated against fills for the single array write port. Fills
// normally win. While the queue is full, fill and store alternate so neither
// side starves. Loads are stalled while a queued or issuing write targets the
// same index. A flush stops new traffic and drains the queue.
//
// Ports
//   clk, reset                        clock, async active-high reset
//   st_valid/st_ready/st_addr/st_way/st_be/st_wd   store request
//   fill_valid/fill_ready/fill_addr/fill_way/fill_wd  line fill request
//   ld_valid/ld_addr/ld_stall         load lookup and hazard stall
//   flush/flush_done                  drain request (level) / completion pulse
//   ram_a/ram_read                    array read port
//   ram_aq/ram_be/ram_wd/ram_write    array write port (ram_write one-hot per way)
//   sq_count/sq_empty                 store-queue occupancy
module dsram_wr_sched #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned WAYS       = 4,
    parameter int unsigned SQ_DEPTH   = 4,
    localparam int unsigned WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int unsigned PTR_W     = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1,
    localparam int unsigned CNT_W     = $clog2(SQ_DEPTH) + 1,
    localparam int unsigned BE_W      = 32,
    localparam int unsigned DATA_W    = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [WAY_W-1:0]      st_way,
    input  logic [BE_W-1:0]       st_be,
    input  logic [DATA_W-1:0]     st_wd,
    input  logic                  fill_valid,
    output logic                  fill_ready,
    input  logic [ADDR_WIDTH-1:0] fill_addr,
    input  logic [WAY_W-1:0]      fill_way,
    input  logic [DATA_W-1:0]     fill_wd,
    input  logic                  ld_valid,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    output logic                  ld_stall,
    input  logic                  flush,
    output logic                  flush_done,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic                  ram_read,
    output logic [ADDR_WIDTH-1:0] ram_aq,
    output logic [BE_W-1:0]       ram_be,
    output logic [DATA_W-1:0]     ram_wd,
    output logic [WAYS-1:0]       ram_write,
    output logic [CNT_W-1:0]      sq_count,
    output logic                  sq_empty
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [WAY_W-1:0]      way;
        logic [BE_W-1:0]       be;
        logic [DATA_W-1:0]     wd;
    } sq_entry_t;

    state_t              state, state_nxt;
    sq_entry_t           sq_mem [SQ_DEPTH];
    sq_entry_t           head;
    logic [SQ_DEPTH-1:0] sq_vld, sq_vld_nxt, hit_vec;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic                last_fill;
    logic                sq_full, head_vld;
    logic                fill_issue, st_issue, st_accept, wr_issue, q_hit;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign sq_full   = (sq_count == CNT_W'(SQ_DEPTH));
    assign head_vld  = (sq_count != '0);
    assign sq_empty  = (sq_count == '0);
    assign head      = sq_mem[rd_ptr];
    assign st_accept = st_valid & st_ready;
    assign wr_issue  = fill_issue | st_issue;
    assign fill_ready = fill_issue;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, write-port arbitration and handshakes.
    // Reset gates the fill path because fill_valid is not under our control.
    always_comb begin
        state_nxt  = state;
        flush_done = 1'b0;
        fill_issue = 1'b0;
        st_issue   = 1'b0;
        st_ready   = 1'b0;
        case (state)
            RUN: begin
                if (flush) begin
                    state_nxt = FLUSH;
                end
                if (!reset && fill_valid && !(sq_full && last_fill)) begin
                    fill_issue = 1'b1;
                end else if (head_vld) begin
                    st_issue = 1'b1;
                end
                st_ready = !reset && (!sq_full || st_issue);
            end
            FLUSH: begin
                st_issue = head_vld;
                if (!head_vld) begin
                    flush_done = 1'b1;
                    state_nxt  = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Write-port mux from the arbitration winner; idle port drives zeros
    always_comb begin
        ram_aq    = '0;
        ram_be    = '0;
        ram_wd    = '0;
        ram_write = '0;
        if (fill_issue) begin
            ram_aq    = fill_addr;
            ram_be    = '1;
            ram_wd    = fill_wd;
            ram_write = WAYS'(1) << fill_way;
        end else if (st_issue) begin
            ram_aq    = head.addr;
            ram_be    = head.be;
            ram_wd    = head.wd;
            ram_write = WAYS'(1) << head.way;
        end
    end

    // Load hazard: index match against every live entry, way ignored
    for (genvar i = 0; i < SQ_DEPTH; i++) begin : g_hit
        assign hit_vec[i] = sq_vld[i] & (sq_mem[i].addr == ld_addr);
    end

    assign q_hit    = |hit_vec;
    assign ld_stall = ld_valid & (q_hit | (wr_issue & (ram_aq == ld_addr)));
    assign ram_a    = ld_addr;
    assign ram_read = ld_valid & ~ld_stall & ~reset;

    // Entry valid bits; set after clear so a full-queue push/pop keeps the slot live
    always_comb begin
        sq_vld_nxt = sq_vld;
        if (st_issue) begin
            sq_vld_nxt[rd_ptr] = 1'b0;
        end
        if (st_accept) begin
            sq_vld_nxt[wr_ptr] = 1'b1;
        end
    end

    // Queue control and last-winner flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            sq_count  <= '0;
            sq_vld    <= '0;
            last_fill <= 1'b0;
        end else begin
            sq_vld <= sq_vld_nxt;
            if (st_accept) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (st_issue) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (wr_issue) begin
                last_fill <= fill_issue;
            end
            case ({st_accept, st_issue})
                2'b10:   sq_count <= sq_count + CNT_W'(1);
                2'b01:   sq_count <= sq_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Payload storage; liveness is tracked by sq_vld/sq_count, so no reset needed
    always_ff @(posedge clk) begin
        if (st_accept) begin
            sq_mem[wr_ptr] <= '{addr: st_addr, way: st_way, be: st_be, wd: st_wd};
        end
    end

endmodule

// File: tb/tb_dsram_wr_sched.sv
// Scoreboard bench for dsram_wr_sched: stimulus pushes expected writes into
// queues, a negedge monitor pops and compares whenever the array port writes.
module tb_dsram_wr_sched;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         st_valid, st_ready;
    logic [12:0]  st_addr;
    logic [1:0]   st_way;
    logic [31:0]  st_be;
    logic [255:0] st_wd;
    logic         fill_valid, fill_ready;
    logic [12:0]  fill_addr;
    logic [1:0]   fill_way;
    logic [255:0] fill_wd;
    logic         ld_valid;
    logic [12:0]  ld_addr;
    logic         ld_stall;
    logic         flush, flush_done;
    logic [12:0]  ram_a;
    logic         ram_read;
    logic [12:0]  ram_aq;
    logic [31:0]  ram_be;
    logic [255:0] ram_wd;
    logic [3:0]   ram_write;
    logic [2:0]   sq_count;
    logic         sq_empty;

    typedef struct packed {
        logic [12:0]  aq;
        logic [1:0]   way;
        logic [31:0]  be;
        logic [255:0] wd;
    } wr_t;

    wr_t  exp_st_q[$];
    wr_t  exp_fill_q[$];
    logic kind_q[$];      // expected issue order: 1 = fill, 0 = store

    int n_chk  = 0;
    int n_fail = 0;

    dsram_wr_sched dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_way(st_way), .st_be(st_be), .st_wd(st_wd),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr),
        .fill_way(fill_way), .fill_wd(fill_wd),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
        .flush(flush), .flush_done(flush_done),
        .ram_a(ram_a), .ram_read(ram_read), .ram_aq(ram_aq), .ram_be(ram_be),
        .ram_wd(ram_wd), .ram_write(ram_write),
        .sq_count(sq_count), .sq_empty(sq_empty)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] pat(input int n);
        logic [31:0] w;
        w = 32'h5A000000 + 32'(n);
        return {8{w}};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_st(input int a, input int w, input logic [31:0] be,
                            input logic [255:0] wd, input logic accept);
        st_valid = 1'b1;
        st_addr  = 13'(a);
        st_way   = 2'(w);
        st_be    = be;
        st_wd    = wd;
        if (accept) exp_st_q.push_back('{aq: 13'(a), way: 2'(w), be: be, wd: wd});
    endtask

    task automatic drive_fill(input int a, input int w, input logic [255:0] wd,
                              input logic issue);
        fill_valid = 1'b1;
        fill_addr  = 13'(a);
        fill_way   = 2'(w);
        fill_wd    = wd;
        if (issue) exp_fill_q.push_back('{aq: 13'(a), way: 2'(w), be: '1, wd: wd});
    endtask

    // Monitor: every array write must match the next expected write
    logic mon_k;
    logic mon_ok;
    wr_t  mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            if (ram_write != 4'b0) begin
                n_chk++;
                mon_ok = 1'b1;
                if (kind_q.size() == 0) begin
                    mon_ok = 1'b0;
                    mon_k  = 1'b0;
                    mon_e  = '0;
                end else begin
                    mon_k = kind_q.pop_front();
                    if (mon_k && exp_fill_q.size() != 0) mon_e = exp_fill_q.pop_front();
                    else if (!mon_k && exp_st_q.size() != 0) mon_e = exp_st_q.pop_front();
                    else mon_ok = 1'b0;
                end
                if (!mon_ok || fill_ready !== mon_k || ram_write !== (4'(1) << mon_e.way) ||
                    ram_aq !== mon_e.aq || ram_be !== mon_e.be || ram_wd !== mon_e.wd) begin
                    n_fail++;
                    $display("FAIL write: got fill_ready=%b we=%b aq=%0d be=%h wd=%h expected fill_ready=%b way=%0d aq=%0d be=%h wd=%h t=%0t",
                             fill_ready, ram_write, ram_aq, ram_be, ram_wd,
                             mon_k, mon_e.way, mon_e.aq, mon_e.be, mon_e.wd, $time);
                end
            end else begin
                n_chk++;
                if (ram_be !== 32'h0 || fill_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_port: got be=%h fill_ready=%b expected be=0 fill_ready=0 t=%0t",
                             ram_be, fill_ready, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        st_valid = 0; st_addr = 0; st_way = 0; st_be = 0; st_wd = 0;
        fill_valid = 1; fill_addr = 13'd77; fill_way = 0; fill_wd = pat(1);
        ld_valid = 1; ld_addr = 0; flush = 0;
        #2 reset = 1'b1;

        // Reset state, with fill and load requests pending
        repeat (2) @(posedge clk);
        at_neg();
        chk("rst_st_ready",   64'(st_ready), 0);
        chk("rst_fill_ready", 64'(fill_ready), 0);
        chk("rst_ram_write",  64'(ram_write), 0);
        chk("rst_ram_be",     64'(ram_be), 0);
        chk("rst_ram_read",   64'(ram_read), 0);
        chk("rst_ld_stall",   64'(ld_stall), 0);
        chk("rst_sq_count",   64'(sq_count), 0);
        chk("rst_sq_empty",   64'(sq_empty), 1);
        chk("rst_flush_done", 64'(flush_done), 0);

        cyc(); reset = 0; fill_valid = 0; ld_valid = 0;

        // Single store issues the cycle after acceptance
        cyc(); drive_st(5, 2, 32'h0000000F, 256'hDEADBEEF, 1); kind_q.push_back(0);
        at_neg(); chk("s1_st_ready", 64'(st_ready), 1);
        cyc(); st_valid = 0;
        at_neg(); chk("s1_cnt_issue", 64'(sq_count), 1);
        cyc();
        at_neg(); chk("s1_cnt_done", 64'(sq_count), 0); chk("s1_empty", 64'(sq_empty), 1);

        // Load hazards against queued and issuing writes
        cyc(); drive_st(9, 0, 32'hFFFF0000, pat(2), 1); kind_q.push_back(0);
        ld_valid = 1; ld_addr = 13'd9;
        at_neg(); chk("s2_same_cyc_stall", 64'(ld_stall), 0); chk("s2_same_cyc_read", 64'(ram_read), 1);
        chk("s2_ram_a", 64'(ram_a), 9);
        cyc(); st_valid = 0;
        at_neg(); chk("s2_q_stall", 64'(ld_stall), 1); chk("s2_q_read", 64'(ram_read), 0);
        cyc();
        at_neg(); chk("s2_after_stall", 64'(ld_stall), 0); chk("s2_after_read", 64'(ram_read), 1);
        cyc(); drive_fill(20, 3, pat(3), 1); kind_q.push_back(1); ld_addr = 13'd20;
        at_neg(); chk("s2_fill_stall", 64'(ld_stall), 1); chk("s2_fill_read", 64'(ram_read), 0);
        cyc(); fill_valid = 0; ld_addr = 13'd21;
        at_neg(); chk("s2_other_stall", 64'(ld_stall), 0);
        cyc(); ld_valid = 0;

        // Fill queue behind fills, then alternate fill/store while full
        for (int i = 0; i < 4; i++) begin
            cyc(); drive_fill(100 + i, i, pat(10 + i), 1);
            drive_st(200 + i, 3 - i, 32'h000000FF << (8 * i), pat(20 + i), 1);
            kind_q.push_back(1);
            at_neg(); chk("s3_fill_ready", 64'(st_ready), 1);
        end
        cyc(); drive_fill(104, 0, pat(14), 0); drive_st(204, 1, 32'hF0F0F0F0, pat(24), 1);
        kind_q.push_back(0);
        at_neg(); chk("s3_full_ready_drain", 64'(st_ready), 1); chk("s3_full_cnt", 64'(sq_count), 4);
        cyc(); drive_fill(104, 0, pat(14), 1); drive_st(205, 2, 32'h0F0F0F0F, pat(25), 0);
        kind_q.push_back(1);
        at_neg(); chk("s3_full_ready_nodrain", 64'(st_ready), 0);
        cyc(); drive_fill(105, 1, pat(15), 0); drive_st(205, 2, 32'h0F0F0F0F, pat(25), 1);
        kind_q.push_back(0);
        at_neg(); chk("s3_wrap_ready", 64'(st_ready), 1); chk("s3_wrap_cnt", 64'(sq_count), 4);
        cyc(); drive_fill(105, 1, pat(15), 1); drive_st(206, 0, 32'h80000001, pat(26), 0);
        kind_q.push_back(1);
        at_neg(); chk("s3_full_ready_nodrain2", 64'(st_ready), 0);
        cyc(); fill_valid = 0; drive_st(206, 0, 32'h80000001, pat(26), 1);
        kind_q.push_back(0);
        at_neg(); chk("s3_nofill_ready", 64'(st_ready), 1);
        cyc(); st_valid = 0;
        repeat (4) kind_q.push_back(0);
        repeat (4) cyc();
        at_neg(); chk("s3_drained", 64'(sq_empty), 1);

        // Flush drains three queued stores while fills and stores are held off
        for (int i = 0; i < 3; i++) begin
            cyc(); drive_fill(300 + i, i, pat(30 + i), 1);
            drive_st(400 + i, 3 - i, 32'(1) << i, pat(40 + i), 1);
            kind_q.push_back(1);
        end
        cyc(); drive_fill(303, 3, pat(33), 1); st_valid = 0; flush = 1; kind_q.push_back(1);
        at_neg(); chk("s4_run_flush_done", 64'(flush_done), 0);
        cyc(); flush = 0; drive_fill(304, 0, pat(34), 0); drive_st(500, 1, 32'h00FF00FF, pat(50), 0);
        kind_q.push_back(0);
        at_neg(); chk("s4_st_ready", 64'(st_ready), 0); chk("s4_fill_ready", 64'(fill_ready), 0);
        chk("s4_done_early", 64'(flush_done), 0);
        cyc(); kind_q.push_back(0);
        at_neg(); chk("s4_done_early2", 64'(flush_done), 0);
        cyc(); kind_q.push_back(0);
        at_neg(); chk("s4_done_early3", 64'(flush_done), 0); chk("s4_cnt_last", 64'(sq_count), 1);
        cyc();
        at_neg(); chk("s4_flush_done", 64'(flush_done), 1); chk("s4_cnt_zero", 64'(sq_count), 0);
        chk("s4_st_ready_done", 64'(st_ready), 0);
        cyc(); drive_fill(304, 0, pat(34), 1); drive_st(500, 1, 32'h00FF00FF, pat(50), 1);
        kind_q.push_back(1);
        at_neg(); chk("s4_done_pulse", 64'(flush_done), 0); chk("s4_back_run", 64'(st_ready), 1);
        cyc(); fill_valid = 0; st_valid = 0; kind_q.push_back(0);

        // Flush with an empty queue completes on the next cycle
        cyc(); flush = 1;
        at_neg(); chk("s5_done_now", 64'(flush_done), 0);
        cyc(); flush = 0;
        at_neg(); chk("s5_done_next", 64'(flush_done), 1);
        cyc();
        at_neg(); chk("s5_done_once", 64'(flush_done), 0);

        // Reset mid-issue discards queued stores
        for (int i = 0; i < 2; i++) begin
            cyc(); drive_fill(600 + i, i, pat(60 + i), 1);
            drive_st(700 + i, 2, 32'hFFFFFFFF, pat(70 + i), 0);
            kind_q.push_back(1);
        end
        cyc(); st_valid = 0; reset = 1; drive_fill(602, 1, pat(62), 0);
        ld_valid = 1; ld_addr = 13'd700;
        at_neg(); chk("s6_ram_write", 64'(ram_write), 0); chk("s6_empty", 64'(sq_empty), 1);
        chk("s6_fill_ready", 64'(fill_ready), 0); chk("s6_ld_stall", 64'(ld_stall), 0);
        chk("s6_ram_be", 64'(ram_be), 0);
        cyc(); reset = 0; fill_valid = 0; ld_valid = 0;
        drive_st(800, 1, 32'h0000FF00, pat(80), 1); kind_q.push_back(0);
        at_neg(); chk("s6_st_ready", 64'(st_ready), 1);
        cyc(); st_valid = 0;
        at_neg(); chk("s6_cnt_issue", 64'(sq_count), 1);
        cyc();
        at_neg(); chk("s6_empty_after", 64'(sq_empty), 1);

        repeat (3) cyc();
        chk("end_kind_q",  64'(kind_q.size()), 0);
        chk("end_st_q",    64'(exp_st_q.size()), 0);
        chk("end_fill_q",  64'(exp_fill_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
